// File: rtl/offset_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : offset_mixer_pkg
// Description : Shared types and constants for the offset_mixer quad-motor
//               mixer: FSM state encoding, per-motor sign table and the
//               throttle band thresholds/increments used to form the base.
// Revision    : 1.0 - initial release
// ============================================================================
package offset_mixer_pkg;

    // One cycle per state; the sequence is strictly linear.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_MIX0    = 3'd2,
        ST_MIX1    = 3'd3,
        ST_MIX2    = 3'd4,
        ST_MIX3    = 3'd5,
        ST_UPDATE  = 3'd6
    } state_t;

    localparam int N_MOTORS = 4;

    // Motor sign table. Each motor owns a 3-bit field {dy, dr, dp}; a set bit
    // means that deviation is subtracted from the base, a clear bit means it
    // is added.
    //   m0 = B - dp + dr + dy  -> 3'b001
    //   m1 = B - dp - dr - dy  -> 3'b111
    //   m2 = B + dp - dr + dy  -> 3'b010
    //   m3 = B + dp + dr - dy  -> 3'b100
    localparam logic [3*N_MOTORS-1:0] MOTOR_SUB = {3'b100, 3'b010, 3'b111, 3'b001};

    // Throttle bands: inclusive upper limits and the increment applied.
    localparam int THR_LIM0 = 10;
    localparam int THR_LIM1 = 20;
    localparam int THR_LIM2 = 30;
    localparam int THR_INC0 = 2;
    localparam int THR_INC1 = 8;
    localparam int THR_INC2 = 14;
    localparam int THR_INC3 = 20;

    function automatic logic [2:0] motor_sub(input logic [1:0] k);
        return MOTOR_SUB[int'(k)*3 +: 3];
    endfunction

    function automatic int throttle_inc(input int thr);
        if (thr <= THR_LIM0)      return THR_INC0;
        else if (thr <= THR_LIM1) return THR_INC1;
        else if (thr <= THR_LIM2) return THR_INC2;
        else                      return THR_INC3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/offset_mixer_sat.sv
`default_nettype none
// ============================================================================
// Module      : offset_mixer_sat
// Description : Signed four-term add followed by a clamp to [0, MAX_DUTY].
//               Shared by all four MIX states of offset_mixer.
// Ports       : i_base            signed base value (DATA_W+3 bits)
//               i_dp, i_dr, i_dy  signed stick deviations (DATA_W+3 bits)
//               i_sub             {dy,dr,dp} subtract selects (1 = subtract)
//               o_duty            clamped duty (DATA_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module offset_mixer_sat
    import offset_mixer_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_DUTY = 100
) (
    input  logic signed [DATA_W+2:0] i_base,
    input  logic signed [DATA_W+2:0] i_dp,
    input  logic signed [DATA_W+2:0] i_dr,
    input  logic signed [DATA_W+2:0] i_dy,
    input  logic        [2:0]        i_sub,
    output logic        [DATA_W-1:0] o_duty
);

    localparam int SW = DATA_W + 3;
    localparam logic signed [SW-1:0] c_max_v = SW'(MAX_DUTY);

    logic signed [SW-1:0] w_tp;
    logic signed [SW-1:0] w_tr;
    logic signed [SW-1:0] w_ty;
    logic signed [SW-1:0] w_sum;

    always_comb begin
        w_tp  = i_sub[0] ? -i_dp : i_dp;
        w_tr  = i_sub[1] ? -i_dr : i_dr;
        w_ty  = i_sub[2] ? -i_dy : i_dy;
        // Three extra bits of headroom keep this sum from wrapping.
        w_sum = i_base + w_tp + w_tr + w_ty;

        if (w_sum < 0)
            o_duty = '0;
        else if (w_sum > c_max_v)
            o_duty = DATA_W'(MAX_DUTY);
        else
            o_duty = w_sum[DATA_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/offset_mixer.sv
`default_nettype none
// ============================================================================
// Module      : offset_mixer
// Description : Quad-motor stick mixer. Captures a stick sample, forms a
//               banded base from throttle plus signed pitch/roll/yaw
//               deviations, mixes one motor per cycle through a shared
//               add/clamp unit and publishes all four duties at once.
//               Optional build macro SLEW_LIMIT_EN limits each lane's
//               per-update change to +/-SLEW_STEP (disarm bypasses it).
// Ports       : clk         clock, rising edge
//               rst_n       asynchronous active-low reset
//               in_valid    stick sample valid
//               in_ready    high in IDLE only
//               throttle, pitch, roll, yaw  unsigned stick values
//               armed       motors enabled when high
//               motor_duty  lane k at [k*DATA_W +: DATA_W]
//               out_valid   one-cycle pulse when motor_duty updates
// Revision    : 1.0 - initial release
// ============================================================================
module offset_mixer
    import offset_mixer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CENTER    = 20,
    parameter int MAX_DUTY  = 100,
    parameter int SLEW_STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     throttle,
    input  logic [DATA_W-1:0]     pitch,
    input  logic [DATA_W-1:0]     roll,
    input  logic [DATA_W-1:0]     yaw,
    input  logic                  armed,
    output logic [4*DATA_W-1:0]   motor_duty,
    output logic                  out_valid
);

    localparam int SW = DATA_W + 3;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    logic       w_take;
    logic       w_cap_en;
    logic       w_mix_en;
    logic [1:0] w_mix_idx;
    logic       w_upd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (in_valid) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_MIX0;
            ST_MIX0:    state_d = ST_MIX1;
            ST_MIX1:    state_d = ST_MIX2;
            ST_MIX2:    state_d = ST_MIX3;
            ST_MIX3:    state_d = ST_UPDATE;
            ST_UPDATE:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        w_cap_en  = 1'b0;
        w_mix_en  = 1'b0;
        w_mix_idx = 2'd0;
        w_upd_en  = 1'b0;
        case (state_q)
            ST_IDLE:    in_ready = 1'b1;
            ST_CAPTURE: w_cap_en = 1'b1;
            ST_MIX0:    begin w_mix_en = 1'b1; w_mix_idx = 2'd0; end
            ST_MIX1:    begin w_mix_en = 1'b1; w_mix_idx = 2'd1; end
            ST_MIX2:    begin w_mix_en = 1'b1; w_mix_idx = 2'd2; end
            ST_MIX3:    begin w_mix_en = 1'b1; w_mix_idx = 2'd3; end
            ST_UPDATE:  w_upd_en = 1'b1;
            default:    ;
        endcase
    end

    assign w_take = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Sample capture (only on the transfer edge, so later input changes
    // cannot leak into the result)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] thr_q, thr_d;
    logic [DATA_W-1:0] pitch_q, pitch_d;
    logic [DATA_W-1:0] roll_q, roll_d;
    logic [DATA_W-1:0] yaw_q, yaw_d;
    logic              armed_q, armed_d;

    always_comb begin
        thr_d   = thr_q;
        pitch_d = pitch_q;
        roll_d  = roll_q;
        yaw_d   = yaw_q;
        armed_d = armed_q;
        if (w_take) begin
            thr_d   = throttle;
            pitch_d = pitch;
            roll_d  = roll;
            yaw_d   = yaw;
            armed_d = armed;
        end
    end

    // ------------------------------------------------------------------
    // Base and deviations, formed in CAPTURE
    // ------------------------------------------------------------------
    logic signed [SW-1:0] base_q, base_d;
    logic signed [SW-1:0] dp_q, dp_d;
    logic signed [SW-1:0] dr_q, dr_d;
    logic signed [SW-1:0] dy_q, dy_d;

    always_comb begin
        base_d = base_q;
        dp_d   = dp_q;
        dr_d   = dr_q;
        dy_d   = dy_q;
        if (w_cap_en) begin
            base_d = $signed({3'b000, thr_q})   + SW'(throttle_inc(int'(thr_q)));
            dp_d   = $signed({3'b000, pitch_q}) - SW'(CENTER);
            dr_d   = $signed({3'b000, roll_q})  - SW'(CENTER);
            dy_d   = $signed({3'b000, yaw_q})   - SW'(CENTER);
        end
    end

    // ------------------------------------------------------------------
    // Mixing: one motor per MIX state through the shared add/clamp unit
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   w_sat_duty;
    logic [4*DATA_W-1:0] mix_q, mix_d;

    offset_mixer_sat #(
        .DATA_W   (DATA_W),
        .MAX_DUTY (MAX_DUTY)
    ) u_sat (
        .i_base (base_q),
        .i_dp   (dp_q),
        .i_dr   (dr_q),
        .i_dy   (dy_q),
        .i_sub  (motor_sub(w_mix_idx)),
        .o_duty (w_sat_duty)
    );

    always_comb begin
        mix_d = mix_q;
        if (w_mix_en)
            mix_d[int'(w_mix_idx)*DATA_W +: DATA_W] = w_sat_duty;
    end

    // ------------------------------------------------------------------
    // Lane update
    // ------------------------------------------------------------------
    wire [4*DATA_W-1:0] w_new_duty;

    for (genvar k = 0; k < N_MOTORS; k++) begin : g_lane
`ifdef SLEW_LIMIT_EN
        localparam logic [DATA_W-1:0] c_step = DATA_W'(SLEW_STEP);
        logic [DATA_W-1:0] w_prev;
        logic [DATA_W-1:0] w_tgt;
        logic [DATA_W-1:0] w_lane;

        assign w_prev = motor_duty[k*DATA_W +: DATA_W];
        assign w_tgt  = mix_q[k*DATA_W +: DATA_W];

        // Differences are taken larger-minus-smaller so they never wrap.
        always_comb begin
            w_lane = w_tgt;
            if (w_tgt > w_prev) begin
                if ((w_tgt - w_prev) > c_step) w_lane = w_prev + c_step;
            end else if ((w_prev - w_tgt) > c_step) begin
                w_lane = w_prev - c_step;
            end
        end

        assign w_new_duty[k*DATA_W +: DATA_W] = w_lane;
`else
        assign w_new_duty[k*DATA_W +: DATA_W] = mix_q[k*DATA_W +: DATA_W];
`endif
    end

    logic [4*DATA_W-1:0] duty_q, duty_d;
    logic                out_valid_q, out_valid_d;

    // Disarm bypasses any slew limiting and zeroes every lane at once.
    always_comb begin
        duty_d      = duty_q;
        out_valid_d = w_upd_en;
        if (w_upd_en)
            duty_d = armed_q ? w_new_duty : '0;
    end

    assign motor_duty = duty_q;
    assign out_valid  = out_valid_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q       <= '0;
            pitch_q     <= '0;
            roll_q      <= '0;
            yaw_q       <= '0;
            armed_q     <= 1'b0;
            base_q      <= '0;
            dp_q        <= '0;
            dr_q        <= '0;
            dy_q        <= '0;
            mix_q       <= '0;
            duty_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            thr_q       <= thr_d;
            pitch_q     <= pitch_d;
            roll_q      <= roll_d;
            yaw_q       <= yaw_d;
            armed_q     <= armed_d;
            base_q      <= base_d;
            dp_q        <= dp_d;
            dr_q        <= dr_d;
            dy_q        <= dy_d;
            mix_q       <= mix_d;
            duty_q      <= duty_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_offset_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_offset_mixer
// Description : Scoreboard bench for offset_mixer (DATA_W=8, CENTER=20,
//               MAX_DUTY=100, SLEW_STEP=4). Stimulus pushes hand-computed
//               lane values; a monitor pops and compares on out_valid.
//               Honors SLEW_LIMIT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_offset_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  throttle, pitch, roll, yaw;
    logic        armed;
    logic [31:0] motor_duty;
    logic        out_valid;

    offset_mixer #(
        .DATA_W    (8),
        .CENTER    (20),
        .MAX_DUTY  (100),
        .SLEW_STEP (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .throttle   (throttle),
        .pitch      (pitch),
        .roll       (roll),
        .yaw        (yaw),
        .armed      (armed),
        .motor_duty (motor_duty),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    int          t_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] prev_model = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %08h required %08h (t=%0t)", name, act, req, $time);
    endtask

    // Expected lane update: clamped hand values, optionally slew-limited
    // against the previous expected lanes; disarm forces zero.
    function automatic logic [31:0] model(input logic [31:0] prev, input logic [31:0] clamped,
                                          input logic arm);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            int p, t, v;
            p = int'(prev[k*8 +: 8]);
            t = int'(clamped[k*8 +: 8]);
            v = t;
`ifdef SLEW_LIMIT_EN
            if (t > p + 4)      v = p + 4;
            else if (t < p - 4) v = p - 4;
`endif
            if (!arm) v = 0;
            r[k*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out_valid: actual 1 required 0 (t=%0t)", $time);
            end else begin
                logic [31:0] e;
                int          t0;
                e  = exp_q.pop_front();
                t0 = t_q.pop_front();
                check("duty", motor_duty, e);
                check("latency", 32'(cyc - t0), 32'd6);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("idle_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic drive(input logic [7:0] t, p, r, y, input logic a);
        throttle = t; pitch = p; roll = r; yaw = y; armed = a;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        in_valid = 1'b0;
        throttle = 8'hA5; pitch = 8'h5A; roll = 8'hFF; yaw = 8'h00; armed = 1'b0;
    endtask

    task automatic send(input logic [7:0] t, p, r, y, input logic a, input logic [31:0] clamped);
        int low = 0;
        wait_idle();
        drive(t, p, r, y, a);
        prev_model = model(prev_model, clamped, a);
        exp_q.push_back(prev_model);
        t_q.push_back(cyc);
        scramble();
        @(negedge clk);
        while (!in_ready && low < 20) begin
            low++;
            @(negedge clk);
        end
        check("in_ready_low_cycles", 32'(low), 32'd6);
    endtask

    localparam logic [31:0] c_all39 = {8'd39, 8'd39, 8'd39, 8'd39};

    initial begin
        rst_n = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        check("reset_duty", motor_duty, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

`ifdef SLEW_LIMIT_EN
        repeat (9) send(8'd25, 8'd20, 8'd20, 8'd20, 1'b1, c_all39);
`endif
        // Neutral sticks: B = 25 + 14 = 39
        send(8'd25, 8'd20, 8'd20, 8'd20, 1'b1, c_all39);
        // dp = +10: m0=m1=29, m2=m3=49
        send(8'd25, 8'd30, 8'd20, 8'd20, 1'b1, {8'd49, 8'd49, 8'd29, 8'd29});
        // Upper clamp
        send(8'd200, 8'd20, 8'd20, 8'd20, 1'b1, {4{8'd100}});
        // B = 7, dy = -20: m0=m2=0 (lower clamp), m1=m3=27
        send(8'd5, 8'd20, 8'd20, 8'd0, 1'b1, {8'd27, 8'd0, 8'd27, 8'd0});
        // Throttle band edges with neutral sticks
        send(8'd10, 8'd20, 8'd20, 8'd20, 1'b1, {4{8'd12}});
        send(8'd20, 8'd20, 8'd20, 8'd20, 1'b1, {4{8'd28}});
        send(8'd30, 8'd20, 8'd20, 8'd20, 1'b1, {4{8'd44}});
        send(8'd31, 8'd20, 8'd20, 8'd20, 1'b1, {4{8'd51}});

        // in_valid pulsed during MIX1 with different sticks is ignored
        wait_idle();
        drive(8'd25, 8'd20, 8'd20, 8'd20, 1'b1);
        prev_model = model(prev_model, c_all39, 1'b1);
        exp_q.push_back(prev_model);
        t_q.push_back(cyc);
        scramble();
        @(posedge clk);
        @(posedge clk);
        #1;
        throttle = 8'd200; pitch = 8'd0; roll = 8'd90; armed = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        scramble();
        repeat (12) @(negedge clk);

        // Reset during MIX2 discards the in-flight sample
        wait_idle();
        drive(8'd31, 8'd20, 8'd20, 8'd20, 1'b1);
        scramble();
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_duty", motor_duty, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        prev_model = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Disarm zeroes every lane regardless of sticks
        send(8'd25, 8'd20, 8'd20, 8'd20, 1'b1, c_all39);
        send(8'd25, 8'd30, 8'd20, 8'd20, 1'b0, {8'd49, 8'd49, 8'd29, 8'd29});

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("duty_hold", motor_duty, prev_model);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/offset_mixer.md
OFFSET_MIXER -- requirements
Module: offset_mixer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, stick/duty word width.
REQ-002 SHALL have parameter CENTER, default 20, stick neutral value.
REQ-003 SHALL have parameter MAX_DUTY, default 100, upper duty clamp.
REQ-004 SHALL have parameter SLEW_STEP, default 4, max per-update duty change (used only with SLEW_LIMIT_EN).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  stick sample valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a sample.
REQ-009 SHALL have port throttle, pitch, roll, yaw  input  DATA_W each  unsigned stick values.
REQ-010 SHALL have port armed  input  1  motors enabled when high.
REQ-011 SHALL have port motor_duty  output  4*DATA_W  motor k duty at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse when motor_duty updates.

Function
REQ-013 SHALL run FSM IDLE -> CAPTURE -> MIX0 -> MIX1 -> MIX2 -> MIX3 -> UPDATE -> IDLE, one cycle per state.
REQ-014 SHALL assert in_ready only in IDLE; a transfer occurs on in_valid && in_ready, and the block moves to CAPTURE.
REQ-015 SHALL ignore in_valid outside IDLE; input changes during CAPTURE..UPDATE do not affect the result.
REQ-016 SHALL register throttle, pitch, roll, yaw and armed on the transfer edge.
REQ-017 SHALL compute base B in CAPTURE as throttle + 2 (throttle<=10), +8 (<=20), +14 (<=30), else +20.
REQ-018 SHALL compute signed deviations dp=pitch-CENTER, dr=roll-CENTER, dy=yaw-CENTER.
REQ-019 SHALL use signed intermediates of DATA_W+3 bits so that no sum wraps.
REQ-020 SHALL compute in MIXk: m0=B-dp+dr+dy, m1=B-dp-dr-dy, m2=B+dp-dr+dy, m3=B+dp+dr-dy.
REQ-021 SHALL clamp each mk to [0, MAX_DUTY].
REQ-022 SHALL write all four motor_duty lanes simultaneously in UPDATE and pulse out_valid for that one cycle.
REQ-023 SHALL produce a result with latency 6: transfer at edge N, out_valid high after edge N+6.
REQ-024 SHALL write 0 to all lanes in UPDATE when captured armed=0, irrespective of stick values.
REQ-025 SHALL hold motor_duty between updates.

Reset
REQ-026 SHALL, while rst_n=0, force FSM to IDLE, motor_duty=0, out_valid=0, in_ready=1 and clear captured inputs.
REQ-027 SHALL, on reset mid-operation, discard the in-flight sample and produce no out_valid for it.

Configuration
REQ-028 SHALL, when SLEW_LIMIT_EN is defined, limit each lane's change in UPDATE to +/-SLEW_STEP relative to its previous value.
REQ-029 SHALL exempt disarm from the slew limit: with armed=0 the lanes go to 0 immediately.
REQ-030 SHALL, when SLEW_LIMIT_EN is undefined, write clamped values directly, with no slew storage.

Structure
REQ-031 SHALL place the state enum, the motor sign table and the throttle band thresholds/increments in package offset_mixer_pkg.
REQ-032 SHALL implement signed add plus clamp in one sub-module, offset_mixer_sat, instantiated once and shared across MIX states.

Verification (DATA_W=8, CENTER=20, MAX_DUTY=100, SLEW_STEP=4)
REQ-033 SHALL cover: rst_n low -> motor_duty=0, out_valid=0, in_ready=1; release -> no out_valid without a transfer.
REQ-034 SHALL cover: T=25, p=r=y=20, armed=1 -> all lanes 39, out_valid exactly 6 edges after transfer, in_ready low for 6 cycles.
REQ-035 SHALL cover: T=25, p=30, r=y=20 -> m0=m1=29, m2=m3=49.
REQ-036 SHALL cover: T=200 -> all lanes 100; T=5, y=0, p=r=20 -> m0=m2=0, m1=m3=27.
REQ-037 SHALL cover: in_valid pulsed during MIX1 -> ignored; rst_n low during MIX2 -> lanes 0, no out_valid; armed=0 sample -> lanes 0.
REQ-038 SHALL cover, with SLEW_LIMIT_EN: prior lanes 39, then p=30 -> m0=m1=35, m2=m3=43; no define -> 29/49.
